// File: rtl/bram_arbiter.sv
// bram_arbiter
//   Arbiter and sequencer in front of one single-port, read-first BRAM with a
//   1-cycle read latency. Two requesters (A = table loader, B = lookup) share
//   the array, and a hardware sweep can zero every word.
//
//   Build option: BRAM_ARB_FIXED_PRIO_EN
//     defined   -> A always wins a conflict, no round-robin pointer
//     undefined -> round-robin, the requester not served last wins
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     clear_start / clear_busy   start pulse / sweep in progress
//     a_* / b_*                  req, we, addr, wdata in; gnt, rvalid, rdata out
//     mem_*                      BRAM addr, read_write, data_in, clear, data_out
module bram_arbiter #(
  parameter int N = 13,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_start,
  output logic         clear_busy,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [N-1:0] a_addr,
  input  logic [W-1:0] a_wdata,
  output logic         a_gnt,
  output logic         a_rvalid,
  output logic [W-1:0] a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [N-1:0] b_addr,
  input  logic [W-1:0] b_wdata,
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [W-1:0] b_rdata,
  output logic [N-1:0] mem_addr,
  output logic         mem_rw,
  output logic [W-1:0] mem_wdata,
  output logic         mem_clear,
  input  logic [W-1:0] mem_rdata
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam int         STAGES = 2;
  // One extra counter bit: the sweep ends when the count reaches 2**N.
  localparam logic [N:0] CNT_END = {1'b1, {N{1'b0}}};
  localparam logic [N:0] CNT_ONE = {{N{1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [N:0]        clr_cnt;
  logic              can_grant;
  logic              win_we;
  logic [N-1:0]      win_addr;
  logic [W-1:0]      win_wdata;
  logic              vld_in;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:1]   id_pipe;   // 1 = read belongs to B

  // clear_start outranks any request in the cycle it is seen.
  assign can_grant = (state == IDLE) && !clear_start;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  assign a_gnt = can_grant & a_req;
  assign b_gnt = can_grant & b_req & ~a_req;
`else
  logic rr_last_b;  // last served requester was B

  assign a_gnt = can_grant & a_req & (~b_req | rr_last_b);
  assign b_gnt = can_grant & b_req & (~a_req | ~rr_last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rr_last_b <= 1'b1;
    else if (a_gnt || b_gnt) rr_last_b <= b_gnt;
  end
`endif

  always_comb begin
    win_we    = a_we;
    win_addr  = a_addr;
    win_wdata = a_wdata;
    if (b_gnt) begin
      win_we    = b_we;
      win_addr  = b_addr;
      win_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_wdata <= '0;
    end else if (state == IDLE) begin
      if (clear_start) begin
        // Address 0 is driven in the first busy cycle, so the count starts at 1.
        state     <= CLEAR;
        clr_cnt   <= CNT_ONE;
        mem_addr  <= '0;
        mem_rw    <= 1'b1;
        mem_wdata <= '0;
      end else if (a_gnt || b_gnt) begin
        mem_addr  <= win_addr;
        mem_rw    <= win_we;
        mem_wdata <= win_wdata;
      end else begin
        mem_rw    <= 1'b0;
      end
    end else begin
      if (clr_cnt == CNT_END) begin
        state  <= IDLE;
        mem_rw <= 1'b0;
      end else begin
        mem_addr <= clr_cnt[N-1:0];
        clr_cnt  <= clr_cnt + CNT_ONE;
      end
    end
  end

  // Read valid pipe keeps shifting through a sweep so in-flight reads finish.
  assign vld_in = (a_gnt | b_gnt) & ~win_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
      id_pipe  <= {id_pipe[STAGES-1:1], b_gnt};
    end
  end

  assign clear_busy = (state == CLEAR);
  assign a_rvalid   = vld_pipe[STAGES] & ~id_pipe[STAGES];
  assign b_rvalid   = vld_pipe[STAGES] &  id_pipe[STAGES];
  assign a_rdata    = mem_rdata;
  assign b_rdata    = mem_rdata;
  assign mem_clear  = 1'b0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter (N = 4): directed vectors, a shadow memory for
// expected read data, and a scoreboard queue drained by a monitor on rvalid.
module tb_bram_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear_start, clear_busy;
  logic         a_req, a_we, a_gnt, a_rvalid;
  logic [N-1:0] a_addr;
  logic [W-1:0] a_wdata, a_rdata;
  logic         b_req, b_we, b_gnt, b_rvalid;
  logic [N-1:0] b_addr;
  logic [W-1:0] b_wdata, b_rdata;
  logic [N-1:0] mem_addr;
  logic         mem_rw, mem_clear;
  logic [W-1:0] mem_wdata, mem_rdata;

  bram_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(clear_busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_clear(mem_clear), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM, 1-cycle latency; not reset.
  logic [W-1:0] bram [1<<N];
  always @(posedge clk) begin
    if (mem_rw) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit b; logic [W-1:0] d; int at; } exp_t;
  exp_t q[$];
  logic [W-1:0] shadow [1<<N];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read, at its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].at < cyc) begin
        chk("rvalid_missing_at", cyc, q[0].at);
        void'(q.pop_front());
      end
      if (a_rvalid || b_rvalid) begin
        if (q.size() == 0) chk("rvalid_unexpected", {30'd0, a_rvalid, b_rvalid}, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rvalid_cycle", cyc, e.at);
          chk("rvalid_both", a_rvalid & b_rvalid, 0);
          chk("rvalid_owner", b_rvalid, e.b);
          chk("rdata", e.b ? b_rdata : a_rdata, e.d);
        end
      end
    end
  end

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    clear_start = 0;
  endtask

  // One cycle of stimulus; called and returns at posedge + 1.
  task automatic drive(input bit ar, input bit aw, input logic [N-1:0] aa, input logic [W-1:0] ad,
                       input bit br, input bit bw, input logic [N-1:0] ba, input logic [W-1:0] bd,
                       input bit clr, input bit eag, input bit ebg);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    clear_start = clr;
    @(negedge clk);
    chk("a_gnt", a_gnt, eag);
    chk("b_gnt", b_gnt, ebg);
    if (eag) begin
      if (aw) shadow[aa] = ad;
      else    q.push_back('{b: 1'b0, d: shadow[aa], at: cyc + 2});
    end
    if (ebg) begin
      if (bw) shadow[ba] = bd;
      else    q.push_back('{b: 1'b1, d: shadow[ba], at: cyc + 2});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Full sweep after the clear_start cycle; optionally A holds a read of addr 2.
  task automatic sweep(input bit hold_a);
    for (int k = 0; k < (1 << N); k++) begin
      a_req = hold_a; a_we = 0; a_addr = 4'd2;
      clear_start = (k == 5);  // must be ignored mid-sweep
      @(negedge clk);
      chk("sweep_busy", clear_busy, 1);
      chk("sweep_addr", mem_addr, k);
      chk("sweep_rw", mem_rw, 1);
      chk("sweep_wdata", mem_wdata, 0);
      chk("sweep_a_gnt", a_gnt, 0);
      @(posedge clk); #1;
    end
    clear_start = 0;
    @(negedge clk);
    chk("sweep_done_busy", clear_busy, 0);
    chk("sweep_done_a_gnt", a_gnt, hold_a);
    if (hold_a) q.push_back('{b: 1'b0, d: shadow[2], at: cyc + 2});
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < (1 << N); i++) begin bram[i] = '0; shadow[i] = '0; end
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", clear_busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_rw", mem_rw, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_clear", mem_clear, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Write then read by A; BRAM inputs registered one cycle after grant.
    drive(1, 1, 4'd5, 16'h1234, 0, 0, 0, 0, 0, 1, 0);
    chk("wr_mem_addr", mem_addr, 5);
    chk("wr_mem_rw", mem_rw, 1);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    drive(1, 0, 4'd5, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rd_mem_rw", mem_rw, 0);
    drive(0, 0, 0, 0, 1, 1, 4'd3, 16'h00AA, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_mem_rw", mem_rw, 0);
    chk("idle_mem_addr_hold", mem_addr, 3);

    // Conflict: both hold reads for four cycles.
`ifdef BRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) drive(1, 0, 4'd5, 0, 1, 0, 4'd3, 0, 0, 1, 0);
`else
    for (int i = 0; i < 4; i++) drive(1, 0, 4'd5, 0, 1, 0, 4'd3, 0, 0, i % 2 == 0, i % 2 == 1);
`endif

    // Preload FFFF, then clear colliding with an A request.
    for (int i = 0; i < (1 << N); i++) drive(1, 1, i[N-1:0], 16'hFFFF, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 4'd2, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < (1 << N); i++) shadow[i] = '0;
    sweep(1);
    for (int i = 0; i < (1 << N); i++) drive(1, 0, i[N-1:0], 0, 0, 0, 0, 0, 0, 1, 0);

    // In-flight read by B granted the cycle before clear_start.
    drive(0, 0, 0, 0, 1, 1, 4'd3, 16'h00AA, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 4'd3, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < (1 << N); i++) shadow[i] = '0;
    sweep(0);

    // Reset in the cycle where the sweep drives address 7.
    for (int i = 0; i < (1 << N); i++) drive(0, 0, 0, 0, 1, 1, i[N-1:0], 16'hFFFF, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_addr", mem_addr, k);
      if (k == 7) break;
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("abort_busy", clear_busy, 0);
    chk("abort_rw", mem_rw, 0);
    for (int i = 0; i < 7; i++) shadow[i] = '0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_abort_busy", clear_busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < (1 << N); i++)
      if (i != 7) drive(1, 0, i[N-1:0], 0, 0, 0, 0, 0, 0, 1, 0);

    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
